// File: rtl/fifo_wr_pkg.sv
// Shared definitions for the FIFO write-side adapter: FSM encoding and input buffer sizing.
package fifo_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DATA    = 2'd1,
        ST_TRAILER = 2'd2
    } wr_state_e;

    localparam int BUF_DEPTH = 2;
    localparam int BUF_CNT_W = 2;

    function automatic logic [BUF_CNT_W-1:0] next_occupancy(
        input logic [BUF_CNT_W-1:0] cnt,
        input logic                 push,
        input logic                 pop
    );
        logic [BUF_CNT_W-1:0] nxt;
        case ({push, pop})
            2'b10:   nxt = cnt + BUF_CNT_W'(1);
            2'b01:   nxt = cnt - BUF_CNT_W'(1);
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry input buffer with registered in_ready and a bypass path when empty.
module fifo_skid_buf
    import fifo_wr_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam logic [BUF_CNT_W-1:0] DEPTH_C = BUF_CNT_W'(BUF_DEPTH);

    logic [WIDTH-1:0]     mem_r [BUF_DEPTH];
    logic                 rd_ptr_r;
    logic                 wr_ptr_r;
    logic [BUF_CNT_W-1:0] count_r;
    logic                 in_ready_r;

    logic                 empty_s;
    logic                 accept_s;
    logic                 push_s;
    logic                 pop_s;
    logic [BUF_CNT_W-1:0] count_nxt_s;

    assign empty_s  = (count_r == '0);
    assign accept_s = in_valid && in_ready_r;
    // A word accepted while empty goes straight to the consumer if it is taking one.
    assign push_s   = accept_s && !(empty_s && out_ready);
    assign pop_s    = out_ready && !empty_s;

    assign count_nxt_s = next_occupancy(count_r, push_s, pop_s);

    assign out_valid = !empty_s || accept_s;
    assign out_data  = empty_s ? in_data : mem_r[rd_ptr_r];
    assign in_ready  = in_ready_r;

    // Storage, pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rd_ptr_r   <= 1'b0;
            wr_ptr_r   <= 1'b0;
            count_r    <= '0;
            in_ready_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r    <= count_nxt_s;
            in_ready_r <= (count_nxt_s < DEPTH_C);
        end
    end

endmodule

// File: rtl/fifo_wr_adapter.sv
// Packet write adapter: forwards words to a FIFO and appends a word-count trailer after each packet.
module fifo_wr_adapter
    import fifo_wr_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int PKT_CNT_WIDTH = 16
) (
    input  logic                     wr_clk,
    input  logic                     wr_rstn,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    input  logic                     full,
    output logic                     wr_valid,
    output logic [DATA_WIDTH-1:0]    wr_data,
    output logic [PKT_CNT_WIDTH-1:0] pkt_cnt
);

    wr_state_e                state_r;
    logic [DATA_WIDTH-1:0]    word_cnt_r;
    logic                     cur_last_r;
    logic                     wr_valid_r;
    logic [DATA_WIDTH-1:0]    wr_data_r;
    logic [PKT_CNT_WIDTH-1:0] pkt_cnt_r;

    logic                     buf_valid_s;
    logic [DATA_WIDTH:0]      buf_word_s;
    logic                     buf_last_s;
    logic [DATA_WIDTH-1:0]    buf_data_s;
    logic                     xfer_s;
    logic                     out_free_s;
    logic                     last_xfer_s;
    logic                     load_ok_s;

    fifo_skid_buf #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid_buf (
        .clk       (wr_clk),
        .rstn      (wr_rstn),
        .in_valid  (in_valid),
        .in_data   ({in_last, in_data}),
        .in_ready  (in_ready),
        .out_valid (buf_valid_s),
        .out_data  (buf_word_s),
        .out_ready (load_ok_s)
    );

    assign buf_last_s  = buf_word_s[DATA_WIDTH];
    assign buf_data_s  = buf_word_s[DATA_WIDTH-1:0];

    assign xfer_s      = wr_valid_r && !full;
    assign out_free_s  = !wr_valid_r || xfer_s;
    assign last_xfer_s = xfer_s && cur_last_r && (state_r != ST_TRAILER);

    // Decide whether the output stage may take a data word this cycle.
    always_comb begin
        load_ok_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DATA: load_ok_s = out_free_s && !last_xfer_s;
            ST_TRAILER:       load_ok_s = xfer_s;
            default:          load_ok_s = 1'b0;
        endcase
    end

    // Packet FSM with the registered output stage and counters.
    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            state_r    <= ST_IDLE;
            word_cnt_r <= '0;
            cur_last_r <= 1'b0;
            wr_valid_r <= 1'b0;
            wr_data_r  <= '0;
            pkt_cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DATA: begin
                    if (last_xfer_s) begin
                        // Trailer replaces the last word in place so wr_valid never drops.
                        state_r    <= ST_TRAILER;
                        word_cnt_r <= word_cnt_r + DATA_WIDTH'(1);
                        wr_data_r  <= word_cnt_r + DATA_WIDTH'(1);
                        wr_valid_r <= 1'b1;
                        cur_last_r <= 1'b0;
                    end else begin
                        if (xfer_s) begin
                            state_r    <= ST_DATA;
                            word_cnt_r <= word_cnt_r + DATA_WIDTH'(1);
                        end
                        if (load_ok_s) begin
                            wr_valid_r <= buf_valid_s;
                            if (buf_valid_s) begin
                                wr_data_r  <= buf_data_s;
                                cur_last_r <= buf_last_s;
                            end
                        end
                    end
                end
                ST_TRAILER: begin
                    if (xfer_s) begin
                        state_r    <= ST_IDLE;
                        word_cnt_r <= '0;
                        pkt_cnt_r  <= pkt_cnt_r + PKT_CNT_WIDTH'(1);
                        wr_valid_r <= buf_valid_s;
                        if (buf_valid_s) begin
                            wr_data_r  <= buf_data_s;
                            cur_last_r <= buf_last_s;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign wr_valid = wr_valid_r;
    assign wr_data  = wr_data_r;
    assign pkt_cnt  = pkt_cnt_r;

endmodule

// File: tb/tb_fifo_wr_adapter.sv
// Scoreboard bench for fifo_wr_adapter: directed packet cases plus a random full/valid soak.
module tb_fifo_wr_adapter;

    typedef struct packed {
        logic       trl;
        logic [7:0] d;
    } sb_t;

    logic        wr_clk = 1'b0;
    logic        wr_rstn;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        full;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic [15:0] pkt_cnt;

    int          checks = 0;
    int          errors = 0;
    sb_t         sb_q[$];
    sb_t         stim_q[$];
    logic [7:0]  wc = 8'd0;
    int          exp_pkt = 0;
    logic        hold_chk = 1'b0;
    logic [7:0]  hold_data = 8'd0;
    logic        pkt_chk = 1'b0;
    logic [7:0]  last_trl = 8'd0;

    fifo_wr_adapter #(
        .DATA_WIDTH    (8),
        .PKT_CNT_WIDTH (16)
    ) dut (
        .wr_clk   (wr_clk),
        .wr_rstn  (wr_rstn),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .full     (full),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .pkt_cnt  (pkt_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: sample at negedge, drive inputs, update scoreboard for the coming edge.
    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic f, output logic acc);
        sb_t e;
        @(negedge wr_clk);
        if (hold_chk) begin
            check_eq("hold_valid", 32'(wr_valid), 32'd1);
            check_eq("hold_data", 32'(wr_data), 32'(hold_data));
        end
        if (pkt_chk) begin
            check_eq("pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));
            pkt_chk = 1'b0;
        end
        in_valid = v;
        in_data  = d;
        in_last  = l;
        full     = f;
        acc      = v && in_ready;
        if (wr_valid && !f) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_eq(e.trl ? "trailer" : "data", 32'(wr_data), 32'(e.d));
                if (e.trl) begin
                    exp_pkt  = (exp_pkt + 1) % 65536;
                    pkt_chk  = 1'b1;
                    last_trl = wr_data;
                end
            end
        end
        hold_chk  = wr_valid && f;
        hold_data = wr_data;
        if (acc) begin
            wc = wc + 8'd1;
            sb_q.push_back({1'b0, d});
            if (l) begin
                sb_q.push_back({1'b1, wc});
                wc = 8'd0;
            end
        end
    endtask

    task automatic run(input int cycles, input int v_pct, input int f_pct);
        for (int i = 0; i < cycles; i++) begin
            logic v;
            logic f;
            logic acc;
            sb_t  s;
            s = (stim_q.size() != 0) ? stim_q[0] : '0;
            v = (stim_q.size() != 0) && (int'($urandom_range(99)) < v_pct);
            f = (int'($urandom_range(99)) < f_pct);
            step(v, s.d, s.trl, f, acc);
            if (acc) void'(stim_q.pop_front());
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((stim_q.size() != 0 || sb_q.size() != 0 || wr_valid) && n < 3000) begin
            run(1, 100, 0);
            n++;
        end
        run(1, 0, 0);
        check_eq("drain_done", 32'(sb_q.size() + stim_q.size()), 32'd0);
        check_eq("pkt_cnt_end", 32'(pkt_cnt), 32'(exp_pkt));
    endtask

    task automatic add_pkt(input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            stim_q.push_back({(i == len - 1), base + 8'(i)});
        end
    endtask

    task automatic do_reset();
        @(negedge wr_clk);
        wr_rstn  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'd0;
        full     = 1'b0;
        #1;
        check_eq("rst_wr_valid", 32'(wr_valid), 32'd0);
        check_eq("rst_wr_data", 32'(wr_data), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        sb_q.delete();
        stim_q.delete();
        wc       = 8'd0;
        exp_pkt  = 0;
        hold_chk = 1'b0;
        pkt_chk  = 1'b0;
        @(negedge wr_clk);
        @(negedge wr_clk);
        wr_rstn = 1'b1;
        @(posedge wr_clk);
        #1;
        check_eq("rdy_after_rst", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic acc;
        wr_rstn  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;
        full     = 1'b0;
        do_reset();

        // Back-to-back three-word packet: A1 A2 A3 03 on consecutive cycles.
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                step(1'b1, 8'hA1 + 8'(k), (k == 2), 1'b0, acc);
                check_eq("b2b_acc", 32'(acc), 32'd1);
            end else begin
                step(1'b0, 8'd0, 1'b0, 1'b0, acc);
            end
            @(posedge wr_clk);
            #1;
            check_eq("b2b_valid", 32'(wr_valid), (k < 4) ? 32'd1 : 32'd0);
            if (k == 0) check_eq("bypass_data", 32'(wr_data), 32'hA1);
        end
        drain();
        check_eq("trl_3", 32'(last_trl), 32'h03);
        check_eq("pkt_032", 32'(pkt_cnt), 32'd1);

        // Full held for 6 cycles: one word in output plus two buffered, then ready drops.
        add_pkt(6, 8'h40);
        run(6, 100, 100);
        check_eq("full_accepts", 32'(6 - stim_q.size()), 32'd3);
        check_eq("rdy_low_full", 32'(in_ready), 32'd0);
        drain();

        // Three single-word packets.
        do_reset();
        add_pkt(1, 8'h10);
        add_pkt(1, 8'h20);
        add_pkt(1, 8'h30);
        drain();
        check_eq("trl_single", 32'(last_trl), 32'h01);
        check_eq("pkt_034", 32'(pkt_cnt), 32'd3);

        // Trailer wrap at 256 and 257 words.
        add_pkt(256, 8'h00);
        drain();
        check_eq("trl_256", 32'(last_trl), 32'h00);
        add_pkt(257, 8'h00);
        drain();
        check_eq("trl_257", 32'(last_trl), 32'h01);

        // Reset in the middle of a 4-word packet.
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 8'h60 + 8'(k), 1'b0, 1'b0, acc);
        end
        step(1'b0, 8'd0, 1'b0, 1'b0, acc);
        do_reset();
        add_pkt(2, 8'h70);
        drain();
        check_eq("trl_after_rst", 32'(last_trl), 32'h02);
        check_eq("pkt_after_rst", 32'(pkt_cnt), 32'd1);

        // Random valid/full soak.
        for (int c = 0; c < 10000; c++) begin
            if (stim_q.size() < 4) add_pkt(int'($urandom_range(6, 1)), 8'($urandom_range(255)));
            run(1, 70, 40);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_adapter.md
FIFO_WR_ADAPTER -- requirements
Module: fifo_wr_adapter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of in_data, wr_data and trailer word.
REQ-002 Parameter PKT_CNT_WIDTH, default 16: width of pkt_cnt.
REQ-003 wr_clk  input  1  write-side clock; all state on rising edge.
REQ-004 wr_rstn  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_data  input  DATA_WIDTH  upstream word.
REQ-007 in_last  input  1  marks final word of a packet; qualified by in_valid.
REQ-008 in_ready  output  1  adapter can accept a word; registered, not combinationally dependent on in_valid or full.
REQ-009 full  input  1  FIFO full flag; FIFO writes when wr_valid && !full.
REQ-010 wr_valid  output  1  word on wr_data is to be written; registered.
REQ-011 wr_data  output  DATA_WIDTH  word presented to FIFO; registered.
REQ-012 pkt_cnt  output  PKT_CNT_WIDTH  number of trailers written since reset; wraps.

Function
REQ-013 Input accept = in_valid && in_ready; output transfer = wr_valid && !full.
REQ-014 A 2-entry input buffer holds accepted words with their last flag; in_ready = buffer occupancy after the current edge < 2.
REQ-015 Output stage loads when it is empty or transferring this cycle, and the state permits a data load.
REQ-016 Load source: buffer head if buffer non-empty; otherwise the word being accepted this cycle (bypass), giving 1-cycle latency from accept edge to wr_valid high.
REQ-017 Word order on wr_data equals accept order; no word dropped or duplicated under any full pattern.
REQ-018 While wr_valid && full, wr_valid and wr_data hold stable.
REQ-019 States: IDLE (no packet words transferred), DATA (>=1 word of packet transferred, last not yet), TRAILER (trailer on output).
REQ-020 IDLE->DATA on transfer of a non-last data word; IDLE/DATA->TRAILER on transfer of a last-flagged data word.
REQ-021 On entry to TRAILER, output stage loads trailer = packet word count including last word, modulo 2^DATA_WIDTH, and wr_valid stays high.
REQ-022 TRAILER->IDLE on trailer transfer; word count clears; pkt_cnt increments (wraps to 0); output may load next data word in that same cycle.
REQ-023 No data word enters the output stage while in TRAILER; input accepts continue until buffer full.
REQ-024 Word counter increments on each data-word transfer, wraps modulo 2^DATA_WIDTH.
REQ-025 Single-word packet: trailer 0x01 immediately follows the word.

Reset
REQ-026 On wr_rstn low, asynchronously: wr_valid=0, wr_data=0, in_ready=0, pkt_cnt=0, buffer empty, word count 0, state IDLE.
REQ-027 in_ready rises in the first cycle after reset release.
REQ-028 Reset mid-packet discards buffered words and partial count; next packet trailer counts from 1.

Structure
REQ-029 State encoding (IDLE=0, DATA=1, TRAILER=2) and 2-entry buffer depth constant reside in shared package fifo_wr_pkg.
REQ-030 The 2-entry input buffer is sub-module fifo_skid_buf (valid/ready in, valid/ready out, DATA_WIDTH+1 wide).
REQ-031 Target 150-300 lines RTL total.

Verification
REQ-032 full=0, packet 0xA1,0xA2,0xA3(last) back-to-back -> wr_data 0xA1,0xA2,0xA3,0x03 on consecutive cycles, pkt_cnt=1.
REQ-033 full=1 for 6 cycles with in_valid held -> wr_valid/wr_data stable, in_ready low after 2 further accepts; after full=0 all words emerge in order.
REQ-034 Three single-word packets 0x10,0x20,0x30 -> wr_data 0x10,0x01,0x20,0x01,0x30,0x01; pkt_cnt=3.
REQ-035 DATA_WIDTH=8, 256-word packet -> trailer 0x00; 257-word packet -> trailer 0x01.
REQ-036 wr_rstn pulsed low after 2 words of a 4-word packet -> all outputs 0 during reset; following 2-word packet yields trailer 0x02, pkt_cnt=1.
REQ-037 Random full and in_valid for 10k cycles -> scoreboard matches words plus trailers exactly; wr_data never changes while wr_valid && full.
